// File: rtl/femto_periph_pkg.sv
// Shared definitions for the divider peripheral: register offsets,
// STATUS/CTRL bit positions and the divider state encoding.
package femto_periph_pkg;

   // Byte offsets within the peripheral window
   localparam logic [4:0] DIV_OFF_DIVIDEND  = 5'h00;
   localparam logic [4:0] DIV_OFF_DIVISOR   = 5'h04;
   localparam logic [4:0] DIV_OFF_CTRL      = 5'h08;
   localparam logic [4:0] DIV_OFF_STATUS    = 5'h0C;
   localparam logic [4:0] DIV_OFF_QUOTIENT  = 5'h10;
   localparam logic [4:0] DIV_OFF_REMAINDER = 5'h14;

   // CTRL and STATUS bit indices
   localparam int DIV_CTRL_START    = 0;
   localparam int DIV_STAT_BUSY     = 1 - 1;
   localparam int DIV_STAT_DONE     = 1;
   localparam int DIV_STAT_DIV_ZERO = 2;

   // Divider sequencer states
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DZ   = 2'd2,
      DIV_DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// Handshake: i_start is honoured only in IDLE or DONE. o_busy is high from the
// accepting edge until the result edge; o_done is high from the result edge
// until the next accepted start. o_quot/o_rem change only on the result edge.
module div_core
   import femto_periph_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_zero,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem,
   output div_state_t       o_state
);

   localparam int CW = $clog2(WIDTH + 1);

   div_state_t       r_state;
   div_state_t       w_next_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_part;    // partial remainder, one spare bit for the trial subtract
   logic [WIDTH-1:0] r_q;       // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_dz;

   logic             w_accept;
   logic             w_last;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_qbit;
   logic [WIDTH:0]   w_part_next;
   logic [WIDTH-1:0] w_q_next;

   assign w_accept = i_start && ((r_state == DIV_IDLE) || (r_state == DIV_DONE));
   assign w_last   = (r_cnt == CW'(1));

   // One restoring step. Since the partial remainder is always below the
   // divisor, bit WIDTH of the trial difference is set exactly when it is negative.
   always_comb begin
      w_shift     = {r_part[WIDTH-1:0], r_q[WIDTH-1]};
      w_trial     = w_shift - {1'b0, r_dvs};
      w_qbit      = ~w_trial[WIDTH];
      w_part_next = w_qbit ? w_trial : w_shift;
      w_q_next    = {r_q[WIDTH-2:0], w_qbit};
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= DIV_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         DIV_IDLE, DIV_DONE: begin
            if (w_accept) w_next_state = (i_divisor == '0) ? DIV_DZ : DIV_RUN;
         end
         DIV_RUN: begin
            if (w_last) w_next_state = DIV_DONE;
         end
         DIV_DZ: begin
            w_next_state = DIV_DONE;
         end
         default: w_next_state = DIV_IDLE;
      endcase
   end

   // Datapath: load on start, iterate in RUN, commit results on the final step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_part <= '0;
         r_q    <= '0;
         r_dvs  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dz   <= 1'b0;
      end else if (w_accept) begin
         r_cnt  <= (i_divisor == '0) ? '0 : CW'(WIDTH);
         r_part <= '0;
         r_q    <= i_dividend;
         r_dvs  <= i_divisor;
         r_dz   <= 1'b0;
      end else if (r_state == DIV_RUN) begin
         r_part <= w_part_next;
         r_q    <= w_q_next;
         r_cnt  <= r_cnt - CW'(1);
         if (w_last) begin
            r_quot <= w_q_next;
            r_rem  <= w_part_next[WIDTH-1:0];
         end
      end else if (r_state == DIV_DZ) begin
         // r_q still holds the untouched dividend here
         r_quot <= '1;
         r_rem  <= r_q;
         r_dz   <= 1'b1;
      end
   end

   assign o_busy     = (r_state == DIV_RUN) || (r_state == DIV_DZ);
   assign o_done     = (r_state == DIV_DONE);
   assign o_div_zero = r_dz;
   assign o_quot     = r_quot;
   assign o_rem      = r_rem;
   assign o_state    = r_state;

endmodule

// File: rtl/peripheral_div.sv
// Memory-mapped divider peripheral: bus decode, operand registers and a
// registered read port around the iterative div_core. Reads return the value
// held before any same-cycle write; d_out holds between read strobes.
module peripheral_div
   import femto_periph_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_in,
   input  logic             cs,
   input  logic [4:0]       addr,
   input  logic             rd,
   input  logic             wr,
   output logic [WIDTH-1:0] d_out
);

   logic [WIDTH-1:0] r_dividend;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_dout;

   logic             w_wr_en;
   logic             w_rd_en;
   logic             w_core_free;
   logic             w_start;
   logic             w_busy;
   logic             w_done;
   logic             w_div_zero;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   div_state_t       w_core_state;
   logic [WIDTH-1:0] w_status;
   logic [WIDTH-1:0] w_rdata;

   assign w_wr_en     = cs && wr;
   assign w_rd_en     = cs && rd;
   // Operand and CTRL writes land only while the core is not iterating
   assign w_core_free = (w_core_state == DIV_IDLE) || (w_core_state == DIV_DONE);
   assign w_start     = w_wr_en && w_core_free && (addr == DIV_OFF_CTRL) && d_in[DIV_CTRL_START];

   div_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_start),
      .i_dividend (r_dividend),
      .i_divisor  (r_divisor),
      .o_busy     (w_busy),
      .o_done     (w_done),
      .o_div_zero (w_div_zero),
      .o_quot     (w_quot),
      .o_rem      (w_rem),
      .o_state    (w_core_state)
   );

   // Operand register writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dividend <= '0;
         r_divisor  <= '0;
      end else if (w_wr_en && w_core_free) begin
         if (addr == DIV_OFF_DIVIDEND) r_dividend <= d_in;
         if (addr == DIV_OFF_DIVISOR)  r_divisor  <= d_in;
      end
   end

   // STATUS word assembly
   always_comb begin
      w_status                    = '0;
      w_status[DIV_STAT_BUSY]     = w_busy;
      w_status[DIV_STAT_DONE]     = w_done;
      w_status[DIV_STAT_DIV_ZERO] = w_div_zero;
   end

   // Read mux; CTRL is write-only and unmapped offsets read zero
   always_comb begin
      w_rdata = '0;
      case (addr)
         DIV_OFF_DIVIDEND:  w_rdata = r_dividend;
         DIV_OFF_DIVISOR:   w_rdata = r_divisor;
         DIV_OFF_STATUS:    w_rdata = w_status;
         DIV_OFF_QUOTIENT:  w_rdata = w_quot;
         DIV_OFF_REMAINDER: w_rdata = w_rem;
         default:           w_rdata = '0;
      endcase
   end

   // Registered read data, one cycle after the strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_dout <= '0;
      else if (w_rd_en) r_dout <= w_rdata;
   end

   assign d_out = r_dout;

endmodule

// File: tb/tb_peripheral_div.sv
// Bench for peripheral_div: directed bus transactions with literal expected
// values, plus a register-level model whose d_out is compared every cycle.
module tb_peripheral_div;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] d_in;
   logic         cs;
   logic [4:0]   addr;
   logic         rd;
   logic         wr;
   logic [W-1:0] d_out;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   peripheral_div #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .d_in  (d_in),
      .cs    (cs),
      .addr  (addr),
      .rd    (rd),
      .wr    (wr),
      .d_out (d_out)
   );

   // ---------------- model ----------------
   logic [W-1:0] m_dividend, m_divisor, m_quot, m_rem, m_dout, p_q, p_r;
   bit           m_busy, m_done, m_dz, p_dz;
   int           m_left;

   function automatic logic [W-1:0] m_read(input logic [4:0] a);
      case (a)
         5'h00:   return m_dividend;
         5'h04:   return m_divisor;
         5'h0C:   return {29'b0, m_dz, m_done, m_busy};
         5'h10:   return m_quot;
         5'h14:   return m_rem;
         default: return '0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_dividend = '0; m_divisor = '0; m_quot = '0; m_rem = '0; m_dout = '0;
         m_busy = 0; m_done = 0; m_dz = 0; m_left = 0;
      end else begin
         if (cs && rd) m_dout = m_read(addr);
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1; m_dz = p_dz; m_quot = p_q; m_rem = p_r;
            end
         end else if (cs && wr) begin
            if (addr == 5'h00) m_dividend = d_in;
            if (addr == 5'h04) m_divisor  = d_in;
            if (addr == 5'h08 && d_in[0]) begin
               m_busy = 1; m_done = 0; m_dz = 0;
               if (m_divisor == 0) begin
                  m_left = 1; p_q = '1; p_r = m_dividend; p_dz = 1;
               end else begin
                  m_left = W; p_q = m_dividend / m_divisor; p_r = m_dividend % m_divisor; p_dz = 0;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      n_checks++;
      if (d_out !== m_dout) begin
         n_fail++;
         $display("FAIL d_out_vs_model @%0t: got 0x%08h expected 0x%08h", $time, d_out, m_dout);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic bus(input logic c, input logic r, input logic w,
                      input logic [4:0] a, input logic [W-1:0] d);
      cs = c; rd = r; wr = w; addr = a; d_in = d;
      @(posedge clk);
      #1;
      cs = 0; rd = 0; wr = 0;
   endtask

   task automatic read_reg(input logic [4:0] a, output logic [W-1:0] data);
      bus(1, 1, 0, a, '0);
      data = d_out;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [W-1:0] d);
      bus(1, 0, 1, a, d);
   endtask

   task automatic idle(input int n);
      repeat (n) bus(0, 0, 0, 5'h00, '0);
   endtask

   task automatic wait_done(output int busy_reads);
      logic [W-1:0] s;
      busy_reads = 0;
      for (int i = 0; i < 100; i++) begin
         read_reg(5'h0C, s);
         if (!s[0]) return;
         busy_reads++;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: busy still set after 100 status reads");
   endtask

   task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
      logic [W-1:0] v;
      int n;
      write_reg(5'h00, a);
      write_reg(5'h04, b);
      write_reg(5'h08, 32'h1);
      wait_done(n);
      read_reg(5'h10, v); check({name, "_q"}, v, eq);
      read_reg(5'h14, v); check({name, "_r"}, v, er);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] v;
      int n;
      rst = 1; cs = 0; rd = 0; wr = 0; addr = '0; d_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // reset state
      read_reg(5'h00, v); check("rst_dividend", v, 32'h0);
      read_reg(5'h0C, v); check("rst_status", v, 32'h0);
      read_reg(5'h10, v); check("rst_quot", v, 32'h0);

      // basic divide with busy length
      write_reg(5'h00, 32'd100);
      write_reg(5'h04, 32'd7);
      write_reg(5'h08, 32'h1);
      wait_done(n);
      check("basic_busy_cycles", 32'(n), 32'd32);
      read_reg(5'h10, v); check("basic_q", v, 32'd14);
      read_reg(5'h14, v); check("basic_r", v, 32'd2);
      read_reg(5'h0C, v); check("basic_status", v, 32'h2);

      // boundaries
      run_div("max_by_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0);
      run_div("5_by_9",   32'd5,         32'd9, 32'd0,         32'd5);
      run_div("0_by_3",   32'd0,         32'd3, 32'd0,         32'd0);

      // divide by zero
      write_reg(5'h00, 32'h1234);
      write_reg(5'h04, 32'h0);
      write_reg(5'h08, 32'h1);
      wait_done(n);
      check("dz_busy_cycles", 32'(n), 32'd1);
      read_reg(5'h10, v); check("dz_q", v, 32'hFFFF_FFFF);
      read_reg(5'h14, v); check("dz_r", v, 32'h1234);
      read_reg(5'h0C, v); check("dz_status", v, 32'h6);

      // writes while busy are dropped
      write_reg(5'h00, 32'd100);
      write_reg(5'h04, 32'd7);
      write_reg(5'h08, 32'h1);
      idle(4);
      write_reg(5'h04, 32'd3);
      write_reg(5'h08, 32'h1);
      wait_done(n);
      read_reg(5'h10, v); check("busywr_q", v, 32'd14);
      read_reg(5'h14, v); check("busywr_r", v, 32'd2);
      read_reg(5'h04, v); check("busywr_divisor", v, 32'd7);

      // reset in the middle of a division
      write_reg(5'h08, 32'h1);
      idle(9);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      read_reg(5'h00, v); check("midrst_dividend", v, 32'h0);
      read_reg(5'h04, v); check("midrst_divisor", v, 32'h0);
      read_reg(5'h10, v); check("midrst_q", v, 32'h0);
      read_reg(5'h14, v); check("midrst_r", v, 32'h0);
      read_reg(5'h0C, v); check("midrst_status", v, 32'h0);
      run_div("50_by_5", 32'd50, 32'd5, 32'd10, 32'd0);

      // decode gating
      bus(0, 0, 1, 5'h00, 32'hDEAD_BEEF);
      read_reg(5'h00, v); check("nocs_write", v, 32'd50);
      read_reg(5'h18, v); check("unmapped_read", v, 32'h0);
      write_reg(5'h08, 32'hFFFF_FFFE);
      read_reg(5'h0C, v); check("ctrl_bit0_clear", v, 32'h2);

      // simultaneous read and write returns the old value
      bus(1, 1, 1, 5'h00, 32'd77);
      check("rdwr_old_value", d_out, 32'd50);
      read_reg(5'h00, v); check("rdwr_new_value", v, 32'd77);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
